// File: rtl/gpu_cmd_dma.sv
// rtl/gpu_cmd_dma.sv - command-list DMA from SDRAM into the GPU core command port
// Fetches two-word entries over a pipelined read master and replays each as one command write.
module gpu_cmd_dma #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  slave_address,
  input  logic        slave_read_en,
  input  logic        slave_write_en,
  input  logic [31:0] slave_write_data,
  output logic [31:0] slave_read_data,
  output logic        slave_wait_request,
  output logic [31:0] rd_address,
  output logic        rd_read,
  input  logic [31:0] rd_read_data,
  input  logic        rd_read_data_valid,
  input  logic        rd_wait_request,
  output logic [7:0]  cmd_address,
  output logic        cmd_write,
  output logic [31:0] cmd_write_data,
  input  logic        cmd_wait_request,
  output logic        irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int UW = PW + 1;

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t               r_state, w_state_next;
  logic [31:0]          r_base, r_ptr;
  logic [CNT_WIDTH-1:0] r_count, r_remaining;
  logic [CNT_WIDTH:0]   r_words_left;
  logic [UW-1:0]        r_outstanding, r_used;
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [31:0]          r_mem [FIFO_DEPTH];
  logic                 r_busy, r_irq;
  logic [7:0]           r_cmd_address;
  logic [31:0]          r_cmd_data;

  logic        w_ctrl_wr, w_start, w_ack, w_rd_fire, w_push, w_cmd_accept, w_load, w_done;
  logic [UW:0] w_credit;
  logic [31:0] w_word0, w_word1;
  logic        w_unused;

  assign w_ctrl_wr    = slave_write_en && (slave_address == 2'd2);
  assign w_start      = w_ctrl_wr && slave_write_data[0] && !r_busy;
  assign w_ack        = w_ctrl_wr && slave_write_data[1];
  assign w_rd_fire    = rd_read && !rd_wait_request;
  // Returns with nothing outstanding are stale (e.g. issued before a reset) and are dropped.
  assign w_push       = rd_read_data_valid && (r_outstanding != '0);
  assign w_cmd_accept = cmd_write && !cmd_wait_request;
  assign w_done       = r_busy && (r_words_left == '0) &&
                        ((r_remaining == '0) || ((r_remaining == CNT_WIDTH'(1)) && w_cmd_accept));

  assign w_credit = (UW+1)'(r_used) + (UW+1)'(r_outstanding);
  assign rd_read  = (r_words_left != '0) && (w_credit < (UW+1)'(FIFO_DEPTH));

  assign rd_address         = r_ptr;
  assign cmd_write          = (r_state == S_HOLD);
  assign cmd_address        = r_cmd_address;
  assign cmd_write_data     = r_cmd_data;
  assign irq                = r_irq;
  assign slave_wait_request = 1'b0;

  assign w_word0  = r_mem[r_rd_ptr];
  assign w_word1  = r_mem[r_rd_ptr + PW'(1)];
  assign w_unused = ^{slave_read_en, w_word0[31:8]};

  always_comb begin
    slave_read_data = '0;
    case (slave_address)
      2'd0:    slave_read_data = r_base;
      2'd1:    slave_read_data = 32'(r_count);
      2'd2:    slave_read_data = {30'd0, r_irq, r_busy};
      default: slave_read_data = 32'(r_remaining);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base        <= '0;
      r_count       <= '0;
      r_ptr         <= '0;
      r_words_left  <= '0;
      r_remaining   <= '0;
      r_busy        <= 1'b0;
      r_irq         <= 1'b0;
      r_outstanding <= '0;
      r_used        <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      if (slave_write_en && (slave_address == 2'd0)) r_base <= {slave_write_data[31:2], 2'b00};
      if (slave_write_en && (slave_address == 2'd1)) r_count <= slave_write_data[CNT_WIDTH-1:0];
      if (w_start) begin
        r_ptr        <= r_base;
        r_words_left <= {r_count, 1'b0};
        r_remaining  <= r_count;
        r_busy       <= 1'b1;
      end else begin
        if (w_rd_fire) begin
          r_ptr        <= r_ptr + 32'd4;
          r_words_left <= r_words_left - (CNT_WIDTH+1)'(1);
        end
        if (w_cmd_accept) r_remaining <= r_remaining - CNT_WIDTH'(1);
        if (w_done) r_busy <= 1'b0;
      end
      if (w_done) r_irq <= 1'b1;
      else if (w_ack) r_irq <= 1'b0;
      r_outstanding <= r_outstanding + UW'(w_rd_fire) - UW'(w_push);
      r_used        <= r_used + UW'(w_push) - (w_load ? UW'(2) : UW'(0));
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + PW'(2);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rd_read_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_EMPTY;
      r_cmd_address <= '0;
      r_cmd_data    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_cmd_address <= w_word0[7:0];
        r_cmd_data    <= w_word1;
      end
    end
  end

  // An accepted entry is replaced in the same cycle when a full entry is already buffered.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (r_used >= UW'(2)) begin
          w_load       = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      default: begin
        if (!cmd_wait_request) begin
          if (r_used >= UW'(2)) w_load = 1'b1;
          else w_state_next = S_EMPTY;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_gpu_cmd_dma.sv
// tb/tb_gpu_cmd_dma.sv - randomized self-checking bench for gpu_cmd_dma
// Memory contents are a pure function of address; the expected command stream follows from it.
module tb_gpu_cmd_dma;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  slave_address = '0;
  logic        slave_read_en = 1'b0;
  logic        slave_write_en = 1'b0;
  logic [31:0] slave_write_data = '0;
  logic [31:0] slave_read_data;
  logic        slave_wait_request;
  logic [31:0] rd_address;
  logic        rd_read;
  logic [31:0] rd_read_data = '0;
  logic        rd_read_data_valid = 1'b0;
  logic        rd_wait_request = 1'b0;
  logic [7:0]  cmd_address;
  logic        cmd_write;
  logic [31:0] cmd_write_data;
  logic        cmd_wait_request = 1'b0;
  logic        irq;

  gpu_cmd_dma #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .slave_address(slave_address), .slave_read_en(slave_read_en),
    .slave_write_en(slave_write_en), .slave_write_data(slave_write_data),
    .slave_read_data(slave_read_data), .slave_wait_request(slave_wait_request),
    .rd_address(rd_address), .rd_read(rd_read), .rd_read_data(rd_read_data),
    .rd_read_data_valid(rd_read_data_valid), .rd_wait_request(rd_wait_request),
    .cmd_address(cmd_address), .cmd_write(cmd_write), .cmd_write_data(cmd_write_data),
    .cmd_wait_request(cmd_wait_request), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  logic [31:0] ovr [logic [31:0]];
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  typedef struct { int due; logic [31:0] data; } ret_t;
  ret_t rq[$];
  int cyc = 0;
  int rd_pct = 0, cmd_pct = 0, stall_from = -1, stall_to = -1;

  // SDRAM and GPU-core side stimulus, applied just after each rising edge
  always @(posedge clk) begin
    cyc++;
    #1;
    rd_read_data_valid = 1'b0;
    rd_read_data       = '0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      rd_read_data_valid = 1'b1;
      rd_read_data       = rq[0].data;
      rq.delete(0);
    end
    rd_wait_request  = ($urandom_range(0, 99) < rd_pct);
    cmd_wait_request = ($urandom_range(0, 99) < cmd_pct) || (cyc >= stall_from && cyc < stall_to);
  end

  logic [31:0] m_base;
  int          m_count, m_lat, reads_acc, cmd_acc;
  bit          m_active = 0, m_started = 0, m_irq_exp = 0, lowcredit_seen = 0;
  logic        prev_cmdw = 1'b0, prev_cmdwait = 1'b0;
  logic [31:0] rdlog[$];
  logic [7:0]  alog[$];
  logic [31:0] dlog[$];
  int          sum;
  logic        exp_rd;
  logic [31:0] e_a, e_d;

  // Per-cycle compare against the transaction-level model
  always @(negedge clk) begin
    if (m_active) begin
      sum = reads_acc - 2 * (cmd_acc + (cmd_write ? 1 : 0));
      if (!m_started) check("rd_idle", rd_read, 1'b0);
      else begin
        exp_rd = (reads_acc < 2 * m_count) && (sum < DEPTH);
        check("rd_read_rule", rd_read, exp_rd);
        check("credit_bound", (sum >= 0 && sum <= DEPTH), 1'b1);
        if (rd_read) check("rd_address", rd_address, m_base + 32'(4 * reads_acc));
        check("irq_level", irq, m_irq_exp);
      end
      if (prev_cmdw && prev_cmdwait) check("cmd_hold", cmd_write, 1'b1);
      if (cmd_write) begin
        check("cmd_count_bound", (cmd_acc < m_count), 1'b1);
        if (cmd_acc < m_count) begin
          e_a = memf(m_base + 32'(8 * cmd_acc));
          e_d = memf(m_base + 32'(8 * cmd_acc + 4));
          check("cmd_address", cmd_address, e_a[7:0]);
          check("cmd_write_data", cmd_write_data, e_d);
        end
        if (!cmd_wait_request) begin
          cmd_acc++;
          alog.push_back(cmd_address);
          dlog.push_back(cmd_write_data);
          if (cmd_acc == m_count) m_irq_exp = 1;
        end
      end
      if (rd_read && !rd_wait_request) begin
        rdlog.push_back(rd_address);
        rq.push_back('{due: cyc + m_lat, data: memf(rd_address)});
        reads_acc++;
      end
      if (m_started && cyc >= stall_from && cyc < stall_to && !rd_read && reads_acc < 2 * m_count)
        lowcredit_seen = 1;
      prev_cmdw    = cmd_write;
      prev_cmdwait = cmd_wait_request;
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    slave_address    = a;
    slave_write_data = d;
    slave_write_en   = 1'b1;
    @(posedge clk);
    #1;
    slave_write_en   = 1'b0;
    slave_write_data = '0;
  endtask

  task automatic cpu_read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    slave_address = a;
    slave_read_en = 1'b1;
    #1;
    check(name, slave_read_data, exp);
    slave_read_en = 1'b0;
  endtask

  task automatic start_run(input logic [31:0] base, input int count, input int lat,
                           input int rp, input int cp, input int stall_len);
    m_base = base; m_count = count; m_lat = lat;
    reads_acc = 0; cmd_acc = 0; m_irq_exp = 0; m_started = 0; lowcredit_seen = 0;
    prev_cmdw = 1'b0; prev_cmdwait = 1'b0;
    rdlog.delete(); alog.delete(); dlog.delete();
    cpu_write(2'd0, base);
    cpu_write(2'd1, 32'(count));
    rd_pct = rp; cmd_pct = cp;
    stall_from = cyc + 6; stall_to = stall_from + stall_len;
    m_active = 1;
    cpu_write(2'd2, 32'd1);
    m_started = 1;
    check("rd_read_after_start", rd_read, 1'b1);
  endtask

  task automatic finish_run(input bit busy_poke);
    int n;
    n = 0;
    while (!irq && n < 3000) begin
      if (busy_poke && n == 3) cpu_write(2'd2, 32'd1);
      else if (busy_poke && n == 4) cpu_write(2'd1, 32'd9);
      else if (busy_poke && n == 5) cpu_write(2'd0, 32'hDEAD0000);
      else begin
        cpu_read_check("remaining_track", 2'd3, 32'(m_count - cmd_acc));
        wait_cycle();
      end
      n++;
    end
    check("done_in_time", (n < 3000), 1'b1);
    repeat (4) wait_cycle();
    m_active = 0; rd_pct = 0; cmd_pct = 0; stall_from = -1; stall_to = -1;
    check("entries_sent", 32'(cmd_acc), 32'(m_count));
    check("words_read", 32'(reads_acc), 32'(2 * m_count));
    cpu_read_check("status_done", 2'd2, 32'd2);
    cpu_read_check("remaining_done", 2'd3, 32'd0);
    wait_cycle();
    cpu_write(2'd2, 32'd2);
    check("irq_acked", irq, 1'b0);
    cpu_read_check("status_acked", 2'd2, 32'd0);
    wait_cycle();
  endtask

  initial begin
    int n;
    logic [31:0] rb;
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] rb;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_rd_read", rd_read, 1'b0);
    check("rst_rd_address", rd_address, 32'd0);
    check("rst_cmd_write", cmd_write, 1'b0);
    check("rst_cmd_address", cmd_address, 8'd0);
    check("rst_cmd_data", cmd_write_data, 32'd0);
    check("rst_irq", irq, 1'b0);
    check("slave_wait", slave_wait_request, 1'b0);
    cpu_read_check("rst_base", 2'd0, 32'd0);
    cpu_read_check("rst_count", 2'd1, 32'd0);
    wait_cycle();
    cpu_read_check("rst_status", 2'd2, 32'd0);
    cpu_read_check("rst_remaining", 2'd3, 32'd0);
    wait_cycle();

    cpu_write(2'd0, 32'h12345677);
    cpu_read_check("base_low_bits", 2'd0, 32'h12345674);
    cpu_write(2'd1, 32'hABCD1234);
    cpu_read_check("count_width", 2'd1, 32'h00001234);

    ovr[32'h1000] = 32'h10; ovr[32'h1004] = 32'hA;
    ovr[32'h1008] = 32'h11; ovr[32'h100C] = 32'hB;
    ovr[32'h1010] = 32'h0;  ovr[32'h1014] = 32'h0;
    start_run(32'h1000, 3, 1, 0, 0, 0);
    finish_run(0);
    check("list_len", 32'(alog.size()), 32'd3);
    if (alog.size() >= 3) begin
      check("e0_addr", alog[0], 8'h10); check("e0_data", dlog[0], 32'hA);
      check("e1_addr", alog[1], 8'h11); check("e1_data", dlog[1], 32'hB);
      check("e2_addr", alog[2], 8'h00); check("e2_data", dlog[2], 32'h0);
    end
    check("read_count", 32'(rdlog.size()), 32'd6);
    if (rdlog.size() >= 6) begin
      check("first_read", rdlog[0], 32'h1000);
      check("last_read", rdlog[5], 32'h1014);
    end

    start_run(32'h1000, 16, 1, 0, 0, 20);
    finish_run(0);
    check("credit_exhausted", lowcredit_seen, 1'b1);

    start_run(32'h0004_2000, 20, 7, 50, 30, 0);
    finish_run(0);

    cpu_write(2'd1, 32'd0);
    cpu_write(2'd2, 32'd1);
    check("c0_no_read", rd_read, 1'b0);
    check("c0_irq_t1", irq, 1'b0);
    cpu_read_check("c0_busy_t1", 2'd2, 32'd1);
    wait_cycle();
    check("c0_irq_t2", irq, 1'b1);
    check("c0_no_read_t2", rd_read, 1'b0);
    cpu_read_check("c0_status_t2", 2'd2, 32'd2);
    cpu_write(2'd2, 32'd3);
    check("ack_start_irq", irq, 1'b0);
    cpu_read_check("ack_start_status", 2'd2, 32'd1);
    wait_cycle();
    check("ack_start_irq_t2", irq, 1'b1);
    cpu_write(2'd2, 32'd2);
    check("c0_acked", irq, 1'b0);

    start_run(32'h0000_8000, 4, 2, 20, 20, 0);
    finish_run(1);
    cpu_read_check("count_written_busy", 2'd1, 32'd9);

    start_run(32'hFFFFFFF8, 2, 2, 0, 0, 0);
    finish_run(0);
    check("wrap_reads", 32'(rdlog.size()), 32'd4);
    if (rdlog.size() >= 4) begin
      check("wrap_r0", rdlog[0], 32'hFFFFFFF8);
      check("wrap_r1", rdlog[1], 32'hFFFFFFFC);
      check("wrap_r2", rdlog[2], 32'h00000000);
      check("wrap_r3", rdlog[3], 32'h00000004);
    end

    for (int i = 0; i < 3; i++) begin
      rb = $urandom & 32'hFFFFFFFC;
      start_run(rb, $urandom_range(1, 20), $urandom_range(1, 8),
                $urandom_range(0, 60), $urandom_range(0, 60), 0);
      finish_run(0);
    end

    start_run(32'h2000, 8, 10, 0, 0, 0);
    n = 0;
    while (reads_acc < 5 && n < 100) begin
      wait_cycle();
      n++;
    end
    check("five_outstanding", 32'(reads_acc), 32'd5);
    m_active = 0;
    rst = 1'b1;
    wait_cycle();
    rst = 1'b0;
    check("mid_rst_rd_read", rd_read, 1'b0);
    check("mid_rst_rd_address", rd_address, 32'd0);
    check("mid_rst_cmd_write", cmd_write, 1'b0);
    check("mid_rst_cmd_address", cmd_address, 8'd0);
    check("mid_rst_cmd_data", cmd_write_data, 32'd0);
    check("mid_rst_irq", irq, 1'b0);
    cpu_read_check("mid_rst_base", 2'd0, 32'd0);
    cpu_read_check("mid_rst_count", 2'd1, 32'd0);
    wait_cycle();
    cpu_read_check("mid_rst_status", 2'd2, 32'd0);
    cpu_read_check("mid_rst_remaining", 2'd3, 32'd0);
    for (int i = 0; i < 16; i++) begin
      wait_cycle();
      check("late_no_cmd", cmd_write, 1'b0);
      check("late_no_read", rd_read, 1'b0);
    end

    start_run(32'h3000, 5, 3, 0, 0, 0);
    finish_run(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
